quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature decoder for an incremental encoder. It synchronizes and glitch-filters the encoder A/B channels, decodes the Gray-code sequence into single-cycle up/down step commands, and keeps a wrapping signed-agnostic position register with parallel load. It sits between the encoder pins and the downstream counting/timing logic. It produces the enable/up/load style command stream that an up/down counter consumes, and also keeps its own position.

## Interface
- POS_BITS, 16, width of position register and load value
- FILT_LEN, 3, consecutive synchronized samples required to accept a channel change (≥2)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- a_in  in  1  encoder channel A, asynchronous to clk
- b_in  in  1  encoder channel B, asynchronous to clk
- load  in  1  synchronous load of pos from load_val
- load_val  in  POS_BITS  value loaded into pos
- clr_err  in  1  clears sticky err
- step_en  out  1  one-cycle pulse per accepted quadrature step
- step_up  out  1  direction of current/last step: 1 = up, 0 = down; valid when step_en=1, held otherwise
- pos  out  POS_BITS  current position
- err  out  1  sticky illegal-transition flag

## Operation
- Synchronizer: a_in and b_in each pass through 2 flops, giving s2a and s2b.
- Filter, per channel, with a counter cnt and filtered bit f:
  - If s2 == f, then cnt <= 0.
  - Else if cnt == FILT_LEN-1, then f <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - A pulse shorter than FILT_LEN samples at s2 never reaches f.
- FSM states:
  - INIT (after reset): f is not trusted. Leave INIT when both s2a and s2b have each held a constant value for FILT_LEN consecutive samples. On that edge load fa/fb from s2a/s2b, go to TRACK, and emit no step and no err.
  - TRACK: compare the filtered pair {fa,fb} with its one-cycle-delayed copy {pa,pb}.
- Decode, in TRACK:
  - Up sequence is 00→01→11→10→00. Any of these transitions gives step_en=1, step_up=1, pos <= pos+1.
  - The reverse transitions give step_en=1, step_up=0, pos <= pos-1.
  - No change: step_en=0, pos held.
  - Both bits changed: err <= 1, no step, pos held.
- Arithmetic: pos wraps modulo 2^POS_BITS. 0 minus 1 gives all-ones; all-ones plus 1 gives 0.
- load priority: load=1 sets pos <= load_val, even when a step is decoded in the same cycle. step_en and step_up still report that step.
- err priority: a new illegal transition in the same cycle as clr_err leaves err=1.
- Reset values: pos=0, err=0, step_en=0, step_up=0, FSM=INIT. All synchronizer flops, filter flops, cnt and pa/pb are 0.
- Reset asserted mid-operation returns immediately to these values. After release the block re-enters INIT, so a non-00 encoder position at release causes no spurious step or err.

## Timing
- Take a channel change that is stable before clock edge 0 and held:
  - s2 shows the new value after edge 1.
  - f updates at edge FILT_LEN+1.
  - step_en, step_up and pos update at edge FILT_LEN+2, which is edge 5 for the default.
- step_en is high for exactly one cycle per accepted step. Minimum spacing between steps is FILT_LEN cycles.
- load takes effect at the next edge: pos = load_val in the following cycle.
- clr_err takes effect at the next edge.
- Outputs are fully registered. There is no combinational path from any input to any output.
- Inputs must not change faster than FILT_LEN clock periods per channel edge. Faster inputs are filtered out or flagged via err, never miscounted silently.

## Structure
- Package quad_pkg holds:
  - typedef enum logic {INIT, TRACK} qd_state_t
  - 2-bit Gray constants: PH0=2'b00, PH1=2'b01, PH2=2'b11, PH3=2'b10
- Sub-module quad_filt: one instance per channel. It contains the 2-flop synchronizer, the FILT_LEN filter, and a stable_ok output used by INIT.
- Top level holds the FSM, pa/pb, decode, the pos register and err.

## Test plan
- Reset values: hold reset_n=0 with a=b=1, then release. Require:
  - FSM passes through INIT.
  - pos=0, err=0.
  - No step_en pulse within 20 cycles.
- Up count: from 00, apply 01,11,10,00, each held 10 cycles. Require:
  - 4 step_en pulses with step_up=1.
  - Final pos=4.
  - Each pulse arrives at edge 5 after its input change.
- Down wrap: with pos=0, apply 00→10. Require pos=16'hFFFF, step_up=0, err=0.
- Glitch rejection: pulse a_in high for 2 cycles, then back to 0. Require no step_en and pos unchanged.
- Illegal transition: drive 00→11 simultaneously. Require:
  - err=1, pos unchanged, no step_en.
  - Pulsing clr_err gives err=0 next cycle.
- Load/step collision: assert load with load_val=16'h1234 in the cycle an up step is decoded. Require:
  - pos=16'h1234.
  - step_en=1 and step_up=1 for that cycle.
- Reset mid-count: assert reset_n=0 mid-count. Require all outputs zero on that cycle.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and Gray-phase constants for the quadrature decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package quad_pkg;

    typedef enum logic {INIT, TRACK} qd_state_t;

    // Phases of the up-counting Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b10;

    // Phase that follows 'ph' when the encoder turns in the up direction.
    function automatic logic [1:0] gray_next(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH0:     nxt = PH1;
            PH1:     nxt = PH2;
            PH2:     nxt = PH3;
            default: nxt = PH0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_filt.sv
// One encoder channel: 2-flop synchronizer, FILT_LEN-sample glitch filter, stability detect.
// Latency: input edge reaches s2 after 2 edges, filtered f after FILT_LEN+2 edges.
// Backpressure: none; free-running, init_load force-loads f from s2 when the FSM leaves INIT.
module quad_filt #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    input  logic init_load,
    output logic s2,
    output logic f,
    output logic stable_ok
);

    localparam int CW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic          s1_q, s2_q, s3_q;
    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] stab_q, stab_d;

    // Filter and stability counters; init_load seeds f with the current synchronized level.
    always_comb begin
        f_d    = f_q;
        cnt_d  = cnt_q;
        stab_d = stab_q;

        if (init_load) begin
            f_d   = s2_q;
            cnt_d = '0;
        end else if (s2_q == f_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            f_d   = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Counts consecutive equal samples of s2 (saturating).
        if (s2_q != s3_q) begin
            stab_d = '0;
        end else if (stab_q != CNT_MAX) begin
            stab_d = stab_q + 1'b1;
        end
    end

    // Synchronizer chain, filter state and stability counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            f_q    <= 1'b0;
            cnt_q  <= '0;
            stab_q <= '0;
        end else begin
            s1_q   <= d_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            f_q    <= f_d;
            cnt_q  <= cnt_d;
            stab_q <= stab_d;
        end
    end

    assign s2        = s2_q;
    assign f         = f_q;
    // s2 has shown the same value for FILT_LEN samples in a row.
    assign stable_ok = (stab_q == CNT_MAX) && (s2_q == s3_q);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B -> one-cycle up/down step pulses plus wrapping position.
// Latency: a clean channel edge produces step_en/pos update FILT_LEN+2 edges later.
// Backpressure: none; load overrides pos, a new illegal transition beats clr_err.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int POS_BITS = 16,
    parameter int FILT_LEN = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                a_in,
    input  logic                b_in,
    input  logic                load,
    input  logic [POS_BITS-1:0] load_val,
    input  logic                clr_err,
    output logic                step_en,
    output logic                step_up,
    output logic [POS_BITS-1:0] pos,
    output logic                err
);

    logic s2a, s2b, fa, fb, stable_a, stable_b;
    logic init_go;

    qd_state_t           state_q, state_d;
    logic                pa_q, pa_d, pb_q, pb_d;
    logic                step_en_q, step_en_d;
    logic                step_up_q, step_up_d;
    logic [POS_BITS-1:0] pos_q, pos_d;
    logic                err_q, err_d;

    logic [1:0] cur_ph, prev_ph;
    logic       dec_up, dec_dn, dec_bad;

    // Filters are only trusted once both channels have been steady for FILT_LEN samples.
    assign init_go = (state_q == INIT) && stable_a && stable_b;

    quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_in      (a_in),
        .init_load (init_go),
        .s2        (s2a),
        .f         (fa),
        .stable_ok (stable_a)
    );

    quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_in      (b_in),
        .init_load (init_go),
        .s2        (s2b),
        .f         (fb),
        .stable_ok (stable_b)
    );

    assign cur_ph  = {fa, fb};
    assign prev_ph = {pa_q, pb_q};

    // Gray decode of filtered phase against its one-cycle-delayed copy; only meaningful in TRACK.
    always_comb begin
        dec_up  = 1'b0;
        dec_dn  = 1'b0;
        dec_bad = 1'b0;
        if (state_q == TRACK) begin
            dec_up  = (cur_ph == gray_next(prev_ph));
            dec_dn  = (prev_ph == gray_next(cur_ph));
            dec_bad = ((cur_ph ^ prev_ph) == 2'b11);
        end
    end

    // Next-state for FSM, delayed phase, step outputs, position and sticky error.
    always_comb begin
        state_d   = state_q;
        pa_d      = fa;
        pb_d      = fb;
        step_en_d = dec_up | dec_dn;
        step_up_d = step_up_q;
        pos_d     = pos_q;
        err_d     = err_q;

        if (init_go) begin
            state_d = TRACK;
            // Seed the delayed copy with the same value f is loaded with, so no step on entry.
            pa_d    = s2a;
            pb_d    = s2b;
        end

        if (dec_up) begin
            step_up_d = 1'b1;
            pos_d     = pos_q + 1'b1;
        end else if (dec_dn) begin
            step_up_d = 1'b0;
            pos_d     = pos_q - 1'b1;
        end

        if (load) begin
            pos_d = load_val;
        end

        if (dec_bad) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // Registered state and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT;
            pa_q      <= 1'b0;
            pb_q      <= 1'b0;
            step_en_q <= 1'b0;
            step_up_q <= 1'b0;
            pos_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pa_q      <= pa_d;
            pb_q      <= pb_d;
            step_en_q <= step_en_d;
            step_up_q <= step_up_d;
            pos_q     <= pos_d;
            err_q     <= err_d;
        end
    end

    assign step_en = step_en_q;
    assign step_up = step_up_q;
    assign pos     = pos_q;
    assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;
    import quad_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        a_in, b_in;
    logic        load;
    logic [15:0] load_val;
    logic        clr_err;
    logic        step_en, step_up;
    logic [15:0] pos;
    logic        err;

    int tests = 0;
    int fails = 0;

    quad_decoder #(.POS_BITS(16), .FILT_LEN(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_in     (a_in),
        .b_in     (b_in),
        .load     (load),
        .load_val (load_val),
        .clr_err  (clr_err),
        .step_en  (step_en),
        .step_up  (step_up),
        .pos      (pos),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles from a negedge; reports first step_en edge index (edge 0 = first posedge),
    // its direction/position, and the total number of step pulses seen.
    task automatic watch(input int n, output int idx, output int cnt,
                         output logic up, output logic [15:0] p);
        idx = -1; cnt = 0; up = 1'b0; p = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (step_en === 1'b1) begin
                cnt++;
                if (idx < 0) begin
                    idx = k; up = step_up; p = pos;
                end
            end
        end
    endtask

    int          idx, cnt;
    logic        up;
    logic [15:0] p;
    logic [1:0]  up_seq [4];
    logic [1:0]  ph;

    initial begin
        up_seq[0] = 2'b01; up_seq[1] = 2'b11; up_seq[2] = 2'b10; up_seq[3] = 2'b00;
        reset_n = 1'b0; a_in = 1'b1; b_in = 1'b1;
        load = 1'b0; load_val = '0; clr_err = 1'b0;

        // Reset with encoder parked at 11.
        repeat (3) @(negedge clk);
        check("rst_pos", 32'(pos), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_step_en", 32'(step_en), 32'h0);
        reset_n = 1'b1;
        #1;
        check("rst_state_init", 32'(dut.state_q), 32'(INIT));
        @(negedge clk);
        watch(20, idx, cnt, up, p);
        check("rst_no_steps", 32'(cnt), 32'd0);
        check("rst_pos_after", 32'(pos), 32'h0);
        check("rst_err_after", 32'(err), 32'h0);
        check("rst_state_track", 32'(dut.state_q), 32'(TRACK));

        // Re-reset with encoder at 00.
        reset_n = 1'b0; a_in = 1'b0; b_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        watch(20, idx, cnt, up, p);
        check("rst00_no_steps", 32'(cnt), 32'd0);

        // Up count through the full Gray cycle.
        for (int i = 0; i < 4; i++) begin
            ph = up_seq[i];
            a_in = ph[1]; b_in = ph[0];
            watch(10, idx, cnt, up, p);
            check($sformatf("up%0d_edge", i), 32'(idx), 32'd5);
            check($sformatf("up%0d_cnt", i), 32'(cnt), 32'd1);
            check($sformatf("up%0d_dir", i), 32'(up), 32'd1);
            check($sformatf("up%0d_pos", i), 32'(p), 32'(i + 1));
        end
        check("up_final_pos", 32'(pos), 32'd4);

        // Load 0, then step down from 00 to 10 -> wrap to all-ones.
        load = 1'b1; load_val = 16'h0000;
        @(negedge clk);
        load = 1'b0;
        check("load0_pos", 32'(pos), 32'h0);
        a_in = 1'b1; b_in = 1'b0;
        watch(10, idx, cnt, up, p);
        check("dn_edge", 32'(idx), 32'd5);
        check("dn_dir", 32'(up), 32'd0);
        check("dn_wrap_pos", 32'(pos), 32'hFFFF);
        check("dn_err", 32'(err), 32'h0);

        // 10 -> 00 is an up step: all-ones wraps to 0.
        a_in = 1'b0;
        watch(10, idx, cnt, up, p);
        check("upwrap_dir", 32'(up), 32'd1);
        check("upwrap_pos", 32'(pos), 32'h0);

        // Two-sample glitch on A must be filtered.
        a_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_in = 1'b0;
        watch(15, idx, cnt, up, p);
        check("glitch_steps", 32'(cnt), 32'd0);
        check("glitch_pos", 32'(pos), 32'h0);
        check("glitch_err", 32'(err), 32'h0);

        // Illegal 00 -> 11.
        a_in = 1'b1; b_in = 1'b1;
        watch(10, idx, cnt, up, p);
        check("illegal_err", 32'(err), 32'h1);
        check("illegal_steps", 32'(cnt), 32'd0);
        check("illegal_pos", 32'(pos), 32'h0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err", 32'(err), 32'h0);

        // Load collides with an up step (11 -> 10) decoded at edge 5.
        a_in = 1'b1; b_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        load = 1'b1; load_val = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        check("coll_pos", 32'(pos), 32'h1234);
        check("coll_step_en", 32'(step_en), 32'h1);
        check("coll_step_up", 32'(step_up), 32'h1);
        @(negedge clk);
        check("coll_pulse_end", 32'(step_en), 32'h0);
        check("coll_pos_hold", 32'(pos), 32'h1234);

        // Reset asserted mid-count (10 -> 00 in flight).
        a_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_pos", 32'(pos), 32'h0);
        check("midrst_step_en", 32'(step_en), 32'h0);
        check("midrst_step_up", 32'(step_up), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        watch(20, idx, cnt, up, p);
        check("midrst_no_steps", 32'(cnt), 32'd0);
        check("midrst_pos_after", 32'(pos), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
